reg_write_arbiter: RTL and testbench



---
 rtl/hack_arb_pkg.sv | 21 ++
 rtl/reg_write_arbiter_rr_pick.sv | 35 +++
 rtl/reg_write_arbiter.sv | 111 +++++++++++
 tb/tb_reg_write_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hack_arb_pkg.sv
// Shared definitions for the Hack Register write arbiter.
//   HACK_WORD   : width of a Hack Register word
//   arb_state_t : arbiter FSM states (IDLE, GRANT)
//   clog2_n     : pointer width for N requesters (never below 1 bit)
package hack_arb_pkg;

  localparam int HACK_WORD = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic int clog2_n(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Ports:
//   eligible [N]  : requesters that may be granted this edge
//   last_ptr [PW] : index granted most recently
//   valid         : at least one eligible requester
//   idx      [PW] : first eligible index after last_ptr, wrapping modulo N
module rr_pick
  import hack_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2_n(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] last_ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);

  // Scan from the farthest offset down to the nearest so that the
  // closest eligible index after last_ptr is the last one written.
  always_comb begin
    int cand;
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int off = N; off >= 1; off--) begin
      cand = (int'(last_ptr) + off) % N;
      if (eligible[cand]) begin
        valid = 1'b1;
        idx   = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin write arbiter sharing one Hack Register
// between N requesters. One requester is granted per cycle; the grant,
// Register load and Register data are all registered outputs.
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high
//   req       [N]        : per-requester level write request
//   wdata     [N*WIDTH]  : requester i data at [i*WIDTH +: WIDTH]
//   gnt       [N]        : one-hot grant (registered)
//   reg_in    [WIDTH]    : to Register `in` (registered)
//   reg_load             : to Register `load` (registered)
//   reg_out   [WIDTH]    : from Register `out`
//   rd_data   [WIDTH]    : reg_out passed straight through
//   stall_cnt [16]       : saturating count of cycles with a waiting
//                          requester; present only when REG_ARB_STATS_EN
//                          is defined
module reg_write_arbiter
  import hack_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = HACK_WORD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   wdata,
  output logic [N-1:0]         gnt,
  output logic [WIDTH-1:0]     reg_in,
  output logic                 reg_load,
  input  logic [WIDTH-1:0]     reg_out,
  output logic [WIDTH-1:0]     rd_data
`ifdef REG_ARB_STATS_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  localparam int PW = clog2_n(N);

  arb_state_t       state, state_nxt;
  logic [PW-1:0]    last_ptr, ptr_nxt;
  logic [N-1:0]     eligible;
  logic             pick_vld;
  logic [PW-1:0]    pick_idx;
  logic [N-1:0]     gnt_nxt;
  logic             load_nxt;
  logic [WIDTH-1:0] in_nxt;

  assign rd_data = reg_out;

  // In IDLE nothing is granted, so every request is eligible; in GRANT the
  // current holder is masked to forbid back-to-back grants.
  assign eligible = (state == GRANT) ? (req & ~gnt) : req;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .eligible (eligible),
    .last_ptr (last_ptr),
    .valid    (pick_vld),
    .idx      (pick_idx)
  );

  always_comb begin
    state_nxt = IDLE;
    gnt_nxt   = '0;
    load_nxt  = 1'b0;
    in_nxt    = reg_in;
    ptr_nxt   = last_ptr;
    case (state)
      IDLE, GRANT: begin
        if (pick_vld) begin
          state_nxt = GRANT;
          gnt_nxt   = N'(1) << pick_idx;
          load_nxt  = 1'b1;
          in_nxt    = wdata[pick_idx*WIDTH +: WIDTH];
          ptr_nxt   = pick_idx;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Registered outputs: the Register sees load/data one cycle after the pick.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt      <= '0;
      reg_load <= 1'b0;
      reg_in   <= '0;
      last_ptr <= PW'(N - 1);
    end else begin
      gnt      <= gnt_nxt;
      reg_load <= load_nxt;
      reg_in   <= in_nxt;
      last_ptr <= ptr_nxt;
    end
  end

`ifdef REG_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if ((|(req & ~gnt)) && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0]   gnt;
  logic [W-1:0]   reg_in;
  logic           reg_load;
  logic [W-1:0]   reg_out;
  logic [W-1:0]   rd_data;
  logic [W-1:0]   reg_q = '0;
`ifdef REG_ARB_STATS_EN
  logic [15:0]    stall_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  // Reference model state (spec-level: grant index, pointer, register value)
  int          m_win = -1;
  int          m_last = N - 1;
  logic        exp_load = 1'b0;
  logic [W-1:0] exp_in = '0;
  logic [W-1:0] exp_reg = '0;
  logic [N-1:0] exp_gnt = '0;
  int          exp_stall = 0;

  always #5 clk = ~clk;

  // Shared Hack Register: no reset, captures in on load.
  always @(posedge clk) if (reg_load) reg_q <= reg_in;
  assign reg_out = reg_q;

  reg_write_arbiter #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata), .gnt(gnt),
    .reg_in(reg_in), .reg_load(reg_load), .reg_out(reg_out), .rd_data(rd_data)
`ifdef REG_ARB_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Advance model by one edge using the inputs currently applied, then
  // move the bench to #1 after that edge.
  task automatic step();
    int win;
    win = -1;
    if (exp_load) exp_reg = exp_in;
    if (reset) begin
      m_win = -1; m_last = N - 1; exp_load = 1'b0; exp_in = '0; exp_stall = 0;
    end else begin
      for (int i = 0; i < N; i++)
        if (req[i] && (i != m_win)) begin
          if (exp_stall < 65535) exp_stall++;
          break;
        end
      for (int off = 1; off <= N; off++) begin
        int c;
        c = (m_last + off) % N;
        if (req[c] && c != m_win) begin win = c; break; end
      end
      m_win = win;
      if (win >= 0) begin
        exp_load = 1'b1; exp_in = wdata[win*W +: W]; m_last = win;
      end else begin
        exp_load = 1'b0;
      end
    end
    exp_gnt = (m_win >= 0) ? N'(1 << m_win) : '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0;
    step(); step();
    n_total++;
    if ({gnt, reg_load, reg_in} !== {N'(0), 1'b0, 16'h0000})
      $display("FAIL reset: gnt=%b load=%b in=%h, want 0/0/0000", gnt, reg_load, reg_in);
    else n_pass++;
    reset = 1'b0;
    step();
    n_total++;
    if ({gnt, reg_load} !== {N'(0), 1'b0})
      $display("FAIL reset_idle: gnt=%b load=%b, want 0/0", gnt, reg_load);
    else n_pass++;
  endtask

  task automatic test_single();
    bit ok;
    req = 4'b0100; wdata[2*W +: W] = 16'h1234;
    step();
    n_total++;
    if ({gnt, reg_load} !== {4'b0100, 1'b1})
      $display("FAIL single_grant: gnt=%b load=%b, want 0100/1", gnt, reg_load);
    else n_pass++;
    req = '0;
    step();
    n_total++;
    if (rd_data !== 16'h1234)
      $display("FAIL single_rd: rd_data=%h, want 1234", rd_data);
    else n_pass++;
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (reg_load !== 1'b0 || rd_data !== 16'h1234) ok = 1'b0;
    end
    n_total++;
    if (!ok) $display("FAIL single_hold: load=%b rd_data=%h, want 0/1234", reg_load, rd_data);
    else n_pass++;
  endtask

  task automatic test_rotation();
    logic [N-1:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < N; i++) wdata[i*W +: W] = W'(i);
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k < 5) begin
        n_total++;
        if (gnt !== seq[k]) $display("FAIL rotation_gnt%0d: gnt=%b, want %b", k, gnt, seq[k]);
        else n_pass++;
      end
      if (k >= 1) begin
        n_total++;
        if (rd_data !== W'((k - 1) % N))
          $display("FAIL rotation_rd%0d: rd_data=%h, want %h", k, rd_data, W'((k - 1) % N));
        else n_pass++;
      end
    end
    req = '0; step();
  endtask

  task automatic test_fairness();
    logic [N-1:0] seq [3];
    logic [N-1:0] prev;
    seq = '{4'b0001, 4'b0100, 4'b0001};
    reset = 1'b1; step(); reset = 1'b0;
    req = 4'b0100; step(); req = '0; step();
    req = 4'b0101; prev = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_total++;
      if (gnt !== seq[k] || (gnt & prev) != 0)
        $display("FAIL fairness%0d: gnt=%b prev=%b, want %b", k, gnt, prev, seq[k]);
      else n_pass++;
      prev = gnt;
    end
    req = '0; step();
  endtask

  task automatic test_reset_mid();
    req = 4'b0010; wdata[1*W +: W] = 16'hBEEF;
    step();
    n_total++;
    if (gnt !== 4'b0010) $display("FAIL midreset_pre: gnt=%b, want 0010", gnt);
    else n_pass++;
    reset = 1'b1;
    step();
    n_total++;
    if ({rd_data, gnt, reg_load} !== {16'hBEEF, 4'b0000, 1'b0})
      $display("FAIL midreset: rd=%h gnt=%b load=%b, want beef/0000/0", rd_data, gnt, reg_load);
    else n_pass++;
    reset = 1'b0; req = 4'b1000;
    step();
    n_total++;
    if (gnt !== 4'b1000) $display("FAIL midreset_next: gnt=%b, want 1000", gnt);
    else n_pass++;
    req = '0; step();
  endtask

  task automatic test_random();
    int bad;
    logic [N-1:0] prev;
    bad = 0; prev = '0;
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      req = N'($urandom);
      for (int i = 0; i < N; i++) wdata[i*W +: W] = W'($urandom);
      step();
      n_total++;
      if ({gnt, reg_load, reg_in, rd_data} !== {exp_gnt, exp_load, exp_in, exp_reg}) begin
        bad++;
        if (bad < 5)
          $display("FAIL random%0d: gnt=%b load=%b in=%h rd=%h, want %b/%b/%h/%h",
                   c, gnt, reg_load, reg_in, rd_data, exp_gnt, exp_load, exp_in, exp_reg);
      end else n_pass++;
      n_total++;
      if ((gnt & prev) != 0 || $countones(gnt) > 1)
        $display("FAIL random_onehot%0d: gnt=%b prev=%b", c, gnt, prev);
      else n_pass++;
      prev = gnt;
    end
    reset = 1'b0; req = '0; step();
  endtask

`ifdef REG_ARB_STATS_EN
  task automatic test_stats();
    reset = 1'b1; step(); reset = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 8; i++) step();
    n_total++;
    if (stall_cnt !== 16'd8 || exp_stall != 8)
      $display("FAIL stats8: stall_cnt=%0d, want 8", stall_cnt);
    else n_pass++;
    for (int i = 0; i < 70000; i++) step();
    n_total++;
    if (stall_cnt !== 16'hFFFF)
      $display("FAIL stats_sat: stall_cnt=%h, want ffff", stall_cnt);
    else n_pass++;
    req = '0; step();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_fairness();
    test_reset_mid();
    test_random();
`ifdef REG_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
